dcache_flush_ctrl: RTL and testbench

DCACHE_FLUSH_CTRL -- requirements
Module: dcache_flush_ctrl

---
 rtl/dcache_flush_ctrl_pkg.sv | 25 ++
 rtl/dcache_flush_ctrl_lzc.sv | 33 +++
 rtl/dcache_flush_ctrl.sv | 150 +++++++++++++++
 tb/tb_dcache_flush_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_flush_ctrl_pkg.sv
// Shared constants and FSM encoding for the dcache flush controller.
// Geometry follows the write-back dcache: 32 KiB, 8 ways, 128-bit lines.
package dcache_flush_ctrl_pkg;

  localparam int unsigned DcacheByteSize  = 32768;
  localparam int unsigned DcacheSetAssoc  = 8;
  localparam int unsigned DcacheLineWidth = 128;

  localparam int unsigned LineBytes     = DcacheLineWidth / 8;
  localparam int unsigned LineOffset    = $clog2(LineBytes);
  localparam int unsigned DcacheNumWays = DcacheSetAssoc;
  localparam int unsigned DcacheNumSets = DcacheByteSize / (DcacheSetAssoc * LineBytes);

  typedef enum logic [2:0] {
    IDLE,
    READ_SET,
    WAIT_TAG,
    SCAN,
    WB_REQ,
    WB_WAIT,
    INVALIDATE,
    DONE
  } flush_state_e;

endpackage

// File: rtl/dcache_flush_ctrl_lzc.sv
// Trailing-zero counter: index of the lowest set bit, plus an all-zero flag.
module dcache_flush_ctrl_lzc #(
  parameter  int unsigned Width    = 8,
  localparam int unsigned CntWidth = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0]    data,
  output logic [CntWidth-1:0] cnt,
  output logic                empty
);

  logic [Width-1:0] lower_any;
  logic [Width-1:0] first_hot;

  // lower_any[i] is set when any bit below position i is set
  for (genvar gi = 0; gi < Width; gi++) begin : g_prefix
    if (gi == 0) begin : g_lsb
      assign lower_any[gi] = 1'b0;
    end else begin : g_upper
      assign lower_any[gi] = lower_any[gi-1] | data[gi-1];
    end
  end

  assign first_hot = data & ~lower_any;
  assign empty     = ~|data;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < Width; i++) begin
      if (first_hot[i]) cnt = cnt | CntWidth'(i);
    end
  end

endmodule

// File: rtl/dcache_flush_ctrl.sv
// Walks every dcache set, writes back valid+dirty lines one at a time,
// then invalidates the set; acknowledges once all sets are clean.
module dcache_flush_ctrl
  import dcache_flush_ctrl_pkg::*;
#(
  parameter  int unsigned NumSets   = DcacheNumSets,
  parameter  int unsigned NumWays   = DcacheNumWays,
  parameter  int unsigned AddrWidth = 64,
  localparam int unsigned IdxWidth  = $clog2(NumSets),
  localparam int unsigned WayWidth  = $clog2(NumWays),
  localparam int unsigned TagWidth  = AddrWidth - IdxWidth - LineOffset,
  localparam int unsigned CntWidth  = $clog2(NumSets * NumWays) + 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_req_i,
  output logic                         flush_ack_o,
  output logic                         busy_o,
  output logic                         tag_req_o,
  input  logic                         tag_gnt_i,
  output logic [IdxWidth-1:0]          tag_idx_o,
  input  logic [NumWays*TagWidth-1:0]  tag_rdata_i,
  input  logic [NumWays-1:0]           valid_i,
  input  logic [NumWays-1:0]           dirty_i,
  output logic                         wb_req_o,
  input  logic                         wb_gnt_i,
  output logic [AddrWidth-1:0]         wb_addr_o,
  output logic [WayWidth-1:0]          wb_way_o,
  input  logic                         wb_done_i,
  output logic                         inv_req_o,
  input  logic                         inv_gnt_i,
  output logic [CntWidth-1:0]          wb_count_o
);

  flush_state_e                 state_reg, state_next;
  logic [IdxWidth-1:0]          set_reg, set_next;
  logic [NumWays-1:0]           pend_reg, pend_next;
  logic [NumWays*TagWidth-1:0]  tags_reg, tags_next;
  logic [WayWidth-1:0]          way_reg, way_next;
  logic [CntWidth-1:0]          wb_count_reg, wb_count_next;

  logic [TagWidth-1:0]          way_tag [NumWays];
  logic [WayWidth-1:0]          lzc_cnt;
  logic                         lzc_empty;

  for (genvar gi = 0; gi < NumWays; gi++) begin : g_tag_unpack
    assign way_tag[gi] = tags_reg[gi*TagWidth +: TagWidth];
  end

  dcache_flush_ctrl_lzc #(
    .Width (NumWays)
  ) u_lzc (
    .data  (pend_reg),
    .cnt   (lzc_cnt),
    .empty (lzc_empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      set_reg      <= '0;
      pend_reg     <= '0;
      tags_reg     <= '0;
      way_reg      <= '0;
      wb_count_reg <= '0;
    end else begin
      state_reg    <= state_next;
      set_reg      <= set_next;
      pend_reg     <= pend_next;
      tags_reg     <= tags_next;
      way_reg      <= way_next;
      wb_count_reg <= wb_count_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    set_next      = set_reg;
    pend_next     = pend_reg;
    tags_next     = tags_reg;
    way_next      = way_reg;
    wb_count_next = wb_count_reg;
    tag_req_o     = 1'b0;
    wb_req_o      = 1'b0;
    inv_req_o     = 1'b0;
    flush_ack_o   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (flush_req_i) begin
          state_next    = READ_SET;
          set_next      = '0;
          pend_next     = '0;
          wb_count_next = '0;
        end
      end
      READ_SET: begin
        tag_req_o = 1'b1;
        if (tag_gnt_i) state_next = WAIT_TAG;
      end
      WAIT_TAG: begin
        // dirty without valid is stale state and must not be written back
        tags_next  = tag_rdata_i;
        pend_next  = valid_i & dirty_i;
        state_next = SCAN;
      end
      SCAN: begin
        if (lzc_empty) begin
          state_next = INVALIDATE;
        end else begin
          way_next   = lzc_cnt;
          state_next = WB_REQ;
        end
      end
      WB_REQ: begin
        wb_req_o = 1'b1;
        if (wb_gnt_i) state_next = WB_WAIT;
      end
      WB_WAIT: begin
        if (wb_done_i) begin
          pend_next[way_reg] = 1'b0;
          wb_count_next      = wb_count_reg + CntWidth'(1);
          state_next         = SCAN;
        end
      end
      INVALIDATE: begin
        inv_req_o = 1'b1;
        if (inv_gnt_i) begin
          if (set_reg == IdxWidth'(NumSets - 1)) begin
            state_next = DONE;
          end else begin
            set_next   = set_reg + IdxWidth'(1);
            state_next = READ_SET;
          end
        end
      end
      DONE: begin
        flush_ack_o = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy_o     = (state_reg != IDLE);
  assign tag_idx_o  = set_reg;
  assign wb_way_o   = way_reg;
  assign wb_addr_o  = {way_tag[way_reg], set_reg, {LineOffset{1'b0}}};
  assign wb_count_o = wb_count_reg;

endmodule

// File: tb/tb_dcache_flush_ctrl.sv
// Self-checking bench: a behavioural cache/bus environment answers the
// controller, and expected write-back lists come from a set/way walk.
module tb_dcache_flush_ctrl;

  localparam int NS    = 256;
  localparam int NW    = 8;
  localparam int AW    = 64;
  localparam int IW    = 8;
  localparam int WW    = 3;
  localparam int TW    = AW - IW - 4;
  localparam int CW    = 12;
  localparam int LIMIT = 20000;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic            flush_req_i = 1'b0;
  logic            flush_ack_o, busy_o;
  logic            tag_req_o;
  logic            tag_gnt_i = 1'b0;
  logic [IW-1:0]   tag_idx_o;
  logic [NW*TW-1:0] tag_rdata_i = '0;
  logic [NW-1:0]   valid_i = '0;
  logic [NW-1:0]   dirty_i = '0;
  logic            wb_req_o;
  logic            wb_gnt_i = 1'b0;
  logic [AW-1:0]   wb_addr_o;
  logic [WW-1:0]   wb_way_o;
  logic            wb_done_i = 1'b0;
  logic            inv_req_o;
  logic            inv_gnt_i = 1'b0;
  logic [CW-1:0]   wb_count_o;

  dcache_flush_ctrl #(.NumSets(NS), .NumWays(NW), .AddrWidth(AW)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_req_i(flush_req_i), .flush_ack_o(flush_ack_o),
    .busy_o(busy_o), .tag_req_o(tag_req_o), .tag_gnt_i(tag_gnt_i), .tag_idx_o(tag_idx_o),
    .tag_rdata_i(tag_rdata_i), .valid_i(valid_i), .dirty_i(dirty_i),
    .wb_req_o(wb_req_o), .wb_gnt_i(wb_gnt_i), .wb_addr_o(wb_addr_o), .wb_way_o(wb_way_o),
    .wb_done_i(wb_done_i), .inv_req_o(inv_req_o), .inv_gnt_i(inv_gnt_i),
    .wb_count_o(wb_count_o)
  );

  initial forever #5 clk = ~clk;

  // cache contents: init_* is the pre-flush image, live_* is mutated by invalidates
  logic [TW-1:0] init_tag [NS][NW];
  bit            init_valid [NS][NW];
  bit            init_dirty [NS][NW];
  logic [TW-1:0] live_tag [NS][NW];
  bit            live_valid [NS][NW];
  bit            live_dirty [NS][NW];
  bit            inv_seen [NS];

  int checks = 0;
  int failures = 0;
  bit stall_en = 1'b0;
  bit spurious_en = 1'b0;
  int done_min = 0;
  int done_max = 3;
  int tag_reads, inv_count, ack_count, stab_err, first_idx;
  logic [AW-1:0] wb_addr_q [$];
  int            wb_way_q [$];
  logic [AW-1:0] exp_addr_q [$];
  int            exp_way_q [$];

  // environment state
  bit            tag_hs = 0, inv_hs = 0, wb_hs = 0;
  int            tag_hs_idx = 0, inv_hs_idx = 0;
  logic [AW-1:0] wb_hs_addr = '0;
  int            wb_hs_way = 0;
  int            done_cnt = -1;
  int            tag_w = 0, wb_w = 0, inv_w = 0;
  bit            p_tag_req = 0, p_tag_gnt = 0, p_wb_req = 0, p_wb_gnt = 0;
  bit            p_inv_req = 0, p_inv_gnt = 0;
  logic [IW-1:0] p_idx = '0;
  logic [AW-1:0] p_addr = '0;
  logic [WW-1:0] p_way = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_i) begin
        tag_hs = 0; inv_hs = 0; wb_hs = 0; done_cnt = -1;
      end
      if (tag_hs) begin
        for (int w = 0; w < NW; w++) begin
          tag_rdata_i[w*TW +: TW] = live_tag[tag_hs_idx][w];
          valid_i[w] = live_valid[tag_hs_idx][w];
          dirty_i[w] = live_dirty[tag_hs_idx][w];
        end
        tag_reads++;
        if (first_idx < 0) first_idx = tag_hs_idx;
      end else begin
        for (int w = 0; w < NW; w++) tag_rdata_i[w*TW +: TW] = TW'({$urandom(), $urandom()});
        valid_i = NW'($urandom());
        dirty_i = NW'($urandom());
      end
      if (inv_hs) begin
        for (int w = 0; w < NW; w++) begin
          live_valid[inv_hs_idx][w] = 0;
          live_dirty[inv_hs_idx][w] = 0;
        end
        inv_seen[inv_hs_idx] = 1;
        inv_count++;
      end
      if (wb_hs) begin
        wb_addr_q.push_back(wb_hs_addr);
        wb_way_q.push_back(wb_hs_way);
        done_cnt = $urandom_range(done_max, done_min);
      end
      wb_done_i = 1'b0;
      if (done_cnt == 0) begin
        wb_done_i = 1'b1;
        done_cnt = -1;
      end else if (done_cnt > 0) begin
        done_cnt--;
      end
      if (spurious_en && wb_req_o) wb_done_i = 1'b1;
      if (!rst_i) begin
        if (wb_req_o && p_wb_req && !p_wb_gnt && (wb_addr_o !== p_addr || wb_way_o !== p_way))
          stab_err++;
        if (tag_req_o && p_tag_req && !p_tag_gnt && tag_idx_o !== p_idx) stab_err++;
        if (inv_req_o && p_inv_req && !p_inv_gnt && tag_idx_o !== p_idx) stab_err++;
        if (flush_ack_o) ack_count++;
      end
      // grants: either tied high, or each request stalled 0-5 cycles
      if (!stall_en) tag_gnt_i = 1'b1;
      else if (tag_req_o) begin
        if (tag_w == 0) begin tag_gnt_i = 1'b1; tag_w = $urandom_range(5, 0); end
        else begin tag_gnt_i = 1'b0; tag_w--; end
      end else tag_gnt_i = 1'b0;
      if (!stall_en) wb_gnt_i = 1'b1;
      else if (wb_req_o) begin
        if (wb_w == 0) begin wb_gnt_i = 1'b1; wb_w = $urandom_range(5, 0); end
        else begin wb_gnt_i = 1'b0; wb_w--; end
      end else wb_gnt_i = 1'b0;
      if (!stall_en) inv_gnt_i = 1'b1;
      else if (inv_req_o) begin
        if (inv_w == 0) begin inv_gnt_i = 1'b1; inv_w = $urandom_range(5, 0); end
        else begin inv_gnt_i = 1'b0; inv_w--; end
      end else inv_gnt_i = 1'b0;
      tag_hs = tag_req_o && tag_gnt_i;  tag_hs_idx = int'(tag_idx_o);
      inv_hs = inv_req_o && inv_gnt_i;  inv_hs_idx = int'(tag_idx_o);
      wb_hs  = wb_req_o && wb_gnt_i;    wb_hs_addr = wb_addr_o; wb_hs_way = int'(wb_way_o);
      p_tag_req = tag_req_o; p_tag_gnt = tag_gnt_i;
      p_wb_req = wb_req_o;   p_wb_gnt = wb_gnt_i;
      p_inv_req = inv_req_o; p_inv_gnt = inv_gnt_i;
      p_idx = tag_idx_o; p_addr = wb_addr_o; p_way = wb_way_o;
    end
  end

  task automatic fill_cache(input int valid_pct, input int dirty_pct);
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) begin
        init_tag[s][w]   = TW'({$urandom(), $urandom()});
        init_valid[s][w] = ($urandom_range(99, 0) < valid_pct);
        init_dirty[s][w] = ($urandom_range(99, 0) < dirty_pct);
      end
  endtask

  task automatic load_and_predict();
    exp_addr_q.delete();
    exp_way_q.delete();
    for (int s = 0; s < NS; s++) begin
      inv_seen[s] = 0;
      for (int w = 0; w < NW; w++) begin
        live_tag[s][w]   = init_tag[s][w];
        live_valid[s][w] = init_valid[s][w];
        live_dirty[s][w] = init_dirty[s][w];
        // sets in order, ways low to high; only valid and dirty lines are written back
        if (init_valid[s][w] && init_dirty[s][w]) begin
          exp_addr_q.push_back({init_tag[s][w], IW'(s), 4'b0000});
          exp_way_q.push_back(w);
        end
      end
    end
  endtask

  task automatic start_flush();
    @(negedge clk);
    #1;
    tag_reads = 0; inv_count = 0; ack_count = 0; stab_err = 0; first_idx = -1;
    wb_addr_q.delete();
    wb_way_q.delete();
    flush_req_i = 1'b1;
  endtask

  task automatic run_flush(output bit got, output int latency);
    int cyc;
    start_flush();
    got = 0;
    cyc = 0;
    while (!got && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      if (flush_ack_o) begin
        got = 1;
        flush_req_i = 1'b0;
      end else if (spurious_en) begin
        flush_req_i = 1'($urandom_range(1, 0));
      end
    end
    flush_req_i = 1'b0;
    latency = cyc;
    repeat (4) @(negedge clk);
    $display("flush: latency=%0d wb=%0d count=%0d acks=%0d tag_reads=%0d invs=%0d",
             latency, wb_addr_q.size(), wb_count_o, ack_count, tag_reads, inv_count);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    flush_req_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    checks++; if (flush_ack_o !== 1'b0) begin failures++; $display("FAIL reset_ack: got %b want 0", flush_ack_o); end
    checks++; if (tag_req_o !== 1'b0) begin failures++; $display("FAIL reset_tag_req: got %b want 0", tag_req_o); end
    checks++; if (wb_req_o !== 1'b0) begin failures++; $display("FAIL reset_wb_req: got %b want 0", wb_req_o); end
    checks++; if (inv_req_o !== 1'b0) begin failures++; $display("FAIL reset_inv_req: got %b want 0", inv_req_o); end
    checks++; if (wb_count_o !== '0) begin failures++; $display("FAIL reset_count: got %0d want 0", wb_count_o); end
    #1 rst_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_clean_flush();
    bit got; int lat;
    fill_cache(70, 0);
    load_and_predict();
    stall_en = 0; spurious_en = 0; done_min = 0; done_max = 3;
    run_flush(got, lat);
    checks++; if (!got) begin failures++; $display("FAIL clean_timeout: no ack within %0d cycles", LIMIT); end
    checks++; if (lat != 1 + 4*NS) begin failures++; $display("FAIL clean_latency: got %0d want %0d", lat, 1 + 4*NS); end
    checks++; if (tag_reads != NS) begin failures++; $display("FAIL clean_tag_reads: got %0d want %0d", tag_reads, NS); end
    checks++; if (inv_count != NS) begin failures++; $display("FAIL clean_invs: got %0d want %0d", inv_count, NS); end
    checks++; if (wb_addr_q.size() != 0) begin failures++; $display("FAIL clean_wbs: got %0d want 0", wb_addr_q.size()); end
    checks++; if (wb_count_o !== '0) begin failures++; $display("FAIL clean_count: got %0d want 0", wb_count_o); end
    checks++; if (ack_count != 1) begin failures++; $display("FAIL clean_acks: got %0d want 1", ack_count); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL clean_busy: got %b want 0", busy_o); end
  endtask

  task automatic test_directed();
    bit got; int lat; int ok_inv;
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) begin
        init_tag[s][w] = TW'({$urandom(), $urandom()});
        init_valid[s][w] = 0;
        init_dirty[s][w] = 0;
      end
    init_tag[5][2] = TW'(32'h12345); init_valid[5][2] = 1; init_dirty[5][2] = 1;
    init_tag[5][7] = TW'(32'h12345); init_valid[5][7] = 1; init_dirty[5][7] = 1;
    init_valid[5][4] = 1;
    init_dirty[0][3] = 1;
    init_valid[0][1] = 1;
    load_and_predict();
    stall_en = 0; spurious_en = 0; done_min = 0; done_max = 0;
    run_flush(got, lat);
    ok_inv = 1;
    for (int s = 0; s < NS; s++) if (!inv_seen[s]) ok_inv = 0;
    checks++; if (!got) begin failures++; $display("FAIL dir_timeout: no ack within %0d cycles", LIMIT); end
    checks++; if (wb_addr_q.size() != 2) begin failures++; $display("FAIL dir_wb_num: got %0d want 2", wb_addr_q.size()); end
    if (wb_addr_q.size() >= 2) begin
      checks++; if (wb_way_q[0] != 2) begin failures++; $display("FAIL dir_first_way: got %0d want 2", wb_way_q[0]); end
      checks++; if (wb_way_q[1] != 7) begin failures++; $display("FAIL dir_second_way: got %0d want 7", wb_way_q[1]); end
      checks++; if (wb_addr_q[0] !== 64'h12345050) begin failures++; $display("FAIL dir_addr0: got %h want 12345050", wb_addr_q[0]); end
      checks++; if (wb_addr_q[1] !== 64'h12345050) begin failures++; $display("FAIL dir_addr1: got %h want 12345050", wb_addr_q[1]); end
    end
    checks++; if (wb_count_o !== CW'(2)) begin failures++; $display("FAIL dir_count: got %0d want 2", wb_count_o); end
    checks++; if (ok_inv != 1) begin failures++; $display("FAIL dir_all_sets_invalidated: got %0d want 1", ok_inv); end
    // each write-back costs SCAN + WB_REQ + one WB_WAIT cycle on top of the clean path
    checks++; if (lat != 1 + 4*NS + 6) begin failures++; $display("FAIL dir_latency: got %0d want %0d", lat, 1 + 4*NS + 6); end
    checks++; if (ack_count != 1) begin failures++; $display("FAIL dir_acks: got %0d want 1", ack_count); end
  endtask

  task automatic test_random_stall();
    bit got; int lat; int bad; int base_count; int base_acks;
    fill_cache(50, 25);
    load_and_predict();
    stall_en = 0; spurious_en = 0; done_min = 0; done_max = 3;
    run_flush(got, lat);
    base_count = int'(wb_count_o);
    base_acks = ack_count;
    checks++; if (base_count != exp_addr_q.size()) begin failures++; $display("FAIL rnd_base_count: got %0d want %0d", base_count, exp_addr_q.size()); end
    load_and_predict();
    stall_en = 1;
    run_flush(got, lat);
    stall_en = 0;
    bad = 0;
    if (wb_addr_q.size() != exp_addr_q.size()) bad++;
    else for (int i = 0; i < exp_addr_q.size(); i++)
      if (wb_addr_q[i] !== exp_addr_q[i] || wb_way_q[i] != exp_way_q[i]) bad++;
    checks++; if (!got) begin failures++; $display("FAIL stall_timeout: no ack within %0d cycles", LIMIT); end
    checks++; if (bad != 0) begin failures++; $display("FAIL stall_wb_list: got %0d bad entries (n=%0d) want 0 (n=%0d)", bad, wb_addr_q.size(), exp_addr_q.size()); end
    checks++; if (int'(wb_count_o) != base_count) begin failures++; $display("FAIL stall_count: got %0d want %0d", wb_count_o, base_count); end
    checks++; if (ack_count != base_acks || ack_count != 1) begin failures++; $display("FAIL stall_acks: got %0d want 1", ack_count); end
    checks++; if (stab_err != 0) begin failures++; $display("FAIL stall_stability: got %0d changes want 0", stab_err); end
    checks++; if (tag_reads != NS) begin failures++; $display("FAIL stall_tag_reads: got %0d want %0d", tag_reads, NS); end
  endtask

  task automatic test_reset_mid();
    bit got; int lat; int cyc; bit hit; int bad;
    fill_cache(50, 10);
    init_valid[100][1] = 1; init_dirty[100][1] = 1;
    load_and_predict();
    stall_en = 0; spurious_en = 0; done_min = 6; done_max = 6;
    start_flush();
    hit = 0; cyc = 0;
    while (!hit && cyc < LIMIT) begin
      @(negedge clk);
      #2;
      cyc++;
      if (wb_addr_q.size() > 0 && wb_addr_q[wb_addr_q.size()-1][11:4] == 8'd100) hit = 1;
    end
    checks++; if (!hit) begin failures++; $display("FAIL rstmid_reach_set100: not reached within %0d cycles", LIMIT); end
    rst_i = 1'b1;
    flush_req_i = 1'b0;
    @(negedge clk);
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b want 0", busy_o); end
    checks++; if ({wb_req_o, tag_req_o, inv_req_o, flush_ack_o} !== 4'b0) begin failures++; $display("FAIL rstmid_reqs: got %b want 0000", {wb_req_o, tag_req_o, inv_req_o, flush_ack_o}); end
    checks++; if (wb_count_o !== '0) begin failures++; $display("FAIL rstmid_count: got %0d want 0", wb_count_o); end
    checks++; if (ack_count != 0) begin failures++; $display("FAIL rstmid_partial_ack: got %0d want 0", ack_count); end
    #1 rst_i = 1'b0;
    done_min = 0; done_max = 3;
    repeat (2) @(negedge clk);
    load_and_predict();
    run_flush(got, lat);
    bad = 0;
    if (wb_addr_q.size() != exp_addr_q.size()) bad++;
    else for (int i = 0; i < exp_addr_q.size(); i++)
      if (wb_addr_q[i] !== exp_addr_q[i] || wb_way_q[i] != exp_way_q[i]) bad++;
    checks++; if (first_idx != 0) begin failures++; $display("FAIL rstmid_restart_set: got %0d want 0", first_idx); end
    checks++; if (bad != 0) begin failures++; $display("FAIL rstmid_wb_list: got %0d bad entries want 0", bad); end
    checks++; if (int'(wb_count_o) != exp_addr_q.size()) begin failures++; $display("FAIL rstmid_count_after: got %0d want %0d", wb_count_o, exp_addr_q.size()); end
    checks++; if (ack_count != 1) begin failures++; $display("FAIL rstmid_acks: got %0d want 1", ack_count); end
  endtask

  task automatic test_ignored_inputs();
    bit got; int lat; int bad;
    fill_cache(60, 20);
    load_and_predict();
    stall_en = 1; spurious_en = 1; done_min = 0; done_max = 3;
    run_flush(got, lat);
    stall_en = 0; spurious_en = 0;
    bad = 0;
    if (wb_addr_q.size() != exp_addr_q.size()) bad++;
    else for (int i = 0; i < exp_addr_q.size(); i++)
      if (wb_addr_q[i] !== exp_addr_q[i] || wb_way_q[i] != exp_way_q[i]) bad++;
    checks++; if (!got) begin failures++; $display("FAIL ign_timeout: no ack within %0d cycles", LIMIT); end
    checks++; if (ack_count != 1) begin failures++; $display("FAIL ign_acks: got %0d want 1", ack_count); end
    checks++; if (int'(wb_count_o) != exp_addr_q.size()) begin failures++; $display("FAIL ign_count: got %0d want %0d", wb_count_o, exp_addr_q.size()); end
    checks++; if (bad != 0) begin failures++; $display("FAIL ign_wb_list: got %0d bad entries want 0", bad); end
    checks++; if (tag_reads != NS) begin failures++; $display("FAIL ign_tag_reads: got %0d want %0d", tag_reads, NS); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL ign_busy: got %b want 0", busy_o); end
  endtask

  initial begin
    test_reset();
    test_clean_flush();
    test_directed();
    test_random_stall();
    test_reset_mid();
    test_ignored_inputs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
